wb_commit_queue: RTL and testbench

- In-order dual-issue writeback queue. It is the writer side of the 2-write-port general register file.
- Accepts up to two results per cycle from the issue pair: slot0 older, slot1 younger.
- Holds load results until memory returns them by tag.
- Drains up to two completed entries per cycle in program order onto write ports 1 and 2. The older entry always goes to port 1 and the younger to port 2, so the register file's port-2 priority gives correct WAW ordering.

---
 rtl/wb_commit_queue_pkg.sv | 47 ++++
 rtl/wb_commit_queue.sv | 159 +++++++++++++++
 tb/tb_wb_commit_queue.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_queue_pkg.sv
// ============================================================================
// Module  : wb_commit_queue_pkg
// Purpose : Shared register-file defines plus the writeback-queue entry record
//           and sizing constants used by wb_commit_queue.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WB_SHARED_DEFINES
`define WB_SHARED_DEFINES
`define RstEnable    1'b0
`define RstDisable   1'b1
`define WriteEnable  1'b1
`define WriteDisable 1'b0
`define ZeroWord     32'h00000000
`define RegBus       31:0
`define RegAddrBus   4:0
// Writeback-queue sizing
`define WcqDepth     8
`define WcqTagW      3
// Entry record layout, LSB first: pend, wdata, waddr, we, valid
`define WcqEntPend   0
`define WcqEntData   32:1
`define WcqEntAddr   37:33
`define WcqEntWe     38
`define WcqEntValid  39
`define WcqEntryW    40
`endif

package wb_commit_queue_pkg;

  localparam int WCQ_DEPTH = `WcqDepth;
  localparam int WCQ_TAG_W = `WcqTagW;

  // Declaration order gives the bit layout described by the WcqEnt* defines.
  typedef struct packed {
    logic              valid;
    logic              we;
    logic [`RegAddrBus] waddr;
    logic [`RegBus]     wdata;
    logic              pend;
  } wcq_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_commit_queue.sv
// ============================================================================
// Module  : wb_commit_queue
// Purpose : In-order dual-issue writeback queue feeding the two write ports
//           of the general register file. Slot0 is older than slot1. Loads
//           are held pending until filled by tag. Up to two completed
//           entries drain per cycle; the older goes to port 1, the younger
//           to port 2.
// Ports   : clk, rst (async, active low), flush
//           in_valid0/1, in_we0/1, in_waddr0/1, in_wdata0/1, in_pend0/1
//           in_ready, alloc_tag0/1
//           fill_valid, fill_tag, fill_data
//           we1/waddr1/wdata1, we2/waddr2/wdata2
//           count, empty
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_commit_queue
  import wb_commit_queue_pkg::*;
#(
  parameter int DEPTH = WCQ_DEPTH,
  parameter int TAG_W = WCQ_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid0,
  input  logic               in_valid1,
  input  logic               in_we0,
  input  logic               in_we1,
  input  logic [`RegAddrBus] in_waddr0,
  input  logic [`RegAddrBus] in_waddr1,
  input  logic [`RegBus]     in_wdata0,
  input  logic [`RegBus]     in_wdata1,
  input  logic               in_pend0,
  input  logic               in_pend1,
  output logic               in_ready,
  output logic [TAG_W-1:0]   alloc_tag0,
  output logic [TAG_W-1:0]   alloc_tag1,
  input  logic               fill_valid,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [`RegBus]     fill_data,
  output logic               we1,
  output logic [`RegAddrBus] waddr1,
  output logic [`RegBus]     wdata1,
  output logic               we2,
  output logic [`RegAddrBus] waddr2,
  output logic [`RegBus]     wdata2,
  output logic [TAG_W:0]     count,
  output logic               empty
);

  localparam logic [TAG_W:0] c_ready_max = (TAG_W+1)'(DEPTH - 2);

  wcq_entry_t       r_ent [DEPTH];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  logic             w_ready;
  logic             w_acc0;
  logic             w_acc1;
  logic [TAG_W-1:0] w_head1;
  logic [TAG_W-1:0] w_tail1;
  wcq_entry_t       w_h0;
  wcq_entry_t       w_h1;
  logic             w_ret1;
  logic             w_ret2;
  logic [1:0]       w_nenq;
  logic [1:0]       w_ndeq;
  wcq_entry_t       w_slot0;
  wcq_entry_t       w_slot1;
  wcq_entry_t       w_first;
  logic             w_fill_hit;

  // Readiness looks only at the registered count, so drain never feeds back
  // into the issue stage combinationally.
  assign w_ready = (r_count <= c_ready_max);
  assign w_acc0  = in_valid0 & w_ready & ~flush;
  assign w_acc1  = in_valid1 & w_ready & ~flush;
  assign w_nenq  = {1'b0, w_acc0} + {1'b0, w_acc1};

  assign w_head1 = r_head + TAG_W'(1);
  assign w_tail1 = r_tail + TAG_W'(1);

  assign w_h0 = r_ent[r_head];
  assign w_h1 = r_ent[w_head1];

  // Port 2 only ever retires behind port 1 to keep program order.
  assign w_ret1 = ~flush & w_h0.valid & ~w_h0.pend;
  assign w_ret2 = w_ret1 & w_h1.valid & ~w_h1.pend;
  assign w_ndeq = {1'b0, w_ret1} + {1'b0, w_ret2};

  // Pending results carry no data yet; store zero until the fill arrives.
  assign w_slot0 = '{valid: 1'b1, we: in_we0, waddr: in_waddr0,
                     wdata: in_pend0 ? `ZeroWord : in_wdata0, pend: in_pend0};
  assign w_slot1 = '{valid: 1'b1, we: in_we1, waddr: in_waddr1,
                     wdata: in_pend1 ? `ZeroWord : in_wdata1, pend: in_pend1};
  // Compaction: a lone slot1 takes the tail position.
  assign w_first = w_acc0 ? w_slot0 : w_slot1;

  assign w_fill_hit = fill_valid & r_ent[fill_tag].valid & r_ent[fill_tag].pend;

  // Fill targets pending entries, retire targets ready ones and enqueue
  // targets free slots, so the three updates never touch the same entry.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RstEnable) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_fill_hit) begin
        r_ent[fill_tag].wdata <= fill_data;
        r_ent[fill_tag].pend  <= 1'b0;
      end
      if (w_ret1) r_ent[r_head].valid  <= 1'b0;
      if (w_ret2) r_ent[w_head1].valid <= 1'b0;
      if (w_acc0 | w_acc1) r_ent[r_tail]  <= w_first;
      if (w_acc0 & w_acc1) r_ent[w_tail1] <= w_slot1;
      r_head  <= r_head + TAG_W'(w_ndeq);
      r_tail  <= r_tail + TAG_W'(w_nenq);
      r_count <= r_count + (TAG_W+1)'(w_nenq) - (TAG_W+1)'(w_ndeq);
    end
  end

  always_comb begin
    we1    = `WriteDisable;
    waddr1 = '0;
    wdata1 = `ZeroWord;
    we2    = `WriteDisable;
    waddr2 = '0;
    wdata2 = `ZeroWord;
    if (w_ret1) begin
      we1    = w_h0.we;
      waddr1 = w_h0.waddr;
      wdata1 = w_h0.wdata;
    end
    if (w_ret2) begin
      we2    = w_h1.we;
      waddr2 = w_h1.waddr;
      wdata2 = w_h1.wdata;
    end
  end

  assign in_ready   = w_ready;
  assign alloc_tag0 = r_tail;
  assign alloc_tag1 = w_tail1;
  assign count      = r_count;
  assign empty      = (r_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_wb_commit_queue.sv
// ============================================================================
// Module  : tb_wb_commit_queue
// Purpose : Self-checking bench for wb_commit_queue: a table of single-cycle
//           vectors followed by hand-written multi-cycle sequences (full
//           queue and wrap, flush, async reset, ignored fill).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_commit_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid0, in_valid1, in_we0, in_we1, in_pend0, in_pend1;
  logic [4:0]  in_waddr0, in_waddr1;
  logic [31:0] in_wdata0, in_wdata1;
  logic        in_ready;
  logic [2:0]  alloc_tag0, alloc_tag1;
  logic        fill_valid;
  logic [2:0]  fill_tag;
  logic [31:0] fill_data;
  logic        we1, we2;
  logic [4:0]  waddr1, waddr2;
  logic [31:0] wdata1, wdata2;
  logic [3:0]  count;
  logic        empty;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_commit_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .in_we0(in_we0), .in_we1(in_we1),
    .in_waddr0(in_waddr0), .in_waddr1(in_waddr1),
    .in_wdata0(in_wdata0), .in_wdata1(in_wdata1),
    .in_pend0(in_pend0), .in_pend1(in_pend1),
    .in_ready(in_ready), .alloc_tag0(alloc_tag0), .alloc_tag1(alloc_tag1),
    .fill_valid(fill_valid), .fill_tag(fill_tag), .fill_data(fill_data),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .we2(we2), .waddr2(waddr2), .wdata2(wdata2),
    .count(count), .empty(empty)
  );

  typedef struct {
    logic        v0, we0, p0, v1, we1, p1, fv, fl;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1, fd;
    logic [2:0]  ft;
  } in_t;

  typedef struct {
    logic        we1, we2, emp, rdy;
    logic [4:0]  a1, a2;
    logic [31:0] d1, d2;
    logic [3:0]  cnt;
    logic [2:0]  tag0;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  function automatic in_t i_idle();
    in_t r;
    r.v0 = 0; r.we0 = 0; r.p0 = 0; r.a0 = 0; r.d0 = 0;
    r.v1 = 0; r.we1 = 0; r.p1 = 0; r.a1 = 0; r.d1 = 0;
    r.fv = 0; r.ft = 0; r.fd = 0; r.fl = 0;
    return r;
  endfunction

  function automatic in_t i_pair(logic we0, logic [4:0] a0, logic [31:0] d0, logic p0,
                                 logic we1, logic [4:0] a1, logic [31:0] d1, logic p1);
    in_t r = i_idle();
    r.v0 = 1; r.we0 = we0; r.a0 = a0; r.d0 = d0; r.p0 = p0;
    r.v1 = 1; r.we1 = we1; r.a1 = a1; r.d1 = d1; r.p1 = p1;
    return r;
  endfunction

  function automatic in_t i_s0(logic we0, logic [4:0] a0, logic [31:0] d0, logic p0);
    in_t r = i_idle();
    r.v0 = 1; r.we0 = we0; r.a0 = a0; r.d0 = d0; r.p0 = p0;
    return r;
  endfunction

  function automatic in_t i_s1(logic we1, logic [4:0] a1, logic [31:0] d1);
    in_t r = i_idle();
    r.v1 = 1; r.we1 = we1; r.a1 = a1; r.d1 = d1;
    return r;
  endfunction

  function automatic in_t i_fill(logic [2:0] t, logic [31:0] d);
    in_t r = i_idle();
    r.fv = 1; r.ft = t; r.fd = d;
    return r;
  endfunction

  function automatic exp_t mk_e(logic we1_e, logic [4:0] a1, logic [31:0] d1,
                                logic we2_e, logic [4:0] a2, logic [31:0] d2,
                                logic [3:0] cnt, logic emp, logic rdy, logic [2:0] tag0);
    exp_t r;
    r.we1 = we1_e; r.a1 = a1; r.d1 = d1;
    r.we2 = we2_e; r.a2 = a2; r.d2 = d2;
    r.cnt = cnt; r.emp = emp; r.rdy = rdy; r.tag0 = tag0;
    return r;
  endfunction

  function automatic exp_t e_quiet(logic [3:0] cnt, logic emp, logic rdy, logic [2:0] tag0);
    return mk_e(0, 0, 0, 0, 0, 0, cnt, emp, rdy, tag0);
  endfunction

  task automatic drive(input in_t x);
    in_valid0 = x.v0; in_we0 = x.we0; in_waddr0 = x.a0; in_wdata0 = x.d0; in_pend0 = x.p0;
    in_valid1 = x.v1; in_we1 = x.we1; in_waddr1 = x.a1; in_wdata1 = x.d1; in_pend1 = x.p1;
    fill_valid = x.fv; fill_tag = x.ft; fill_data = x.fd; flush = x.fl;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".we1"},    32'(we1),    32'(e.we1));
    chk({tag, ".waddr1"}, 32'(waddr1), 32'(e.a1));
    chk({tag, ".wdata1"}, wdata1,      e.d1);
    chk({tag, ".we2"},    32'(we2),    32'(e.we2));
    chk({tag, ".waddr2"}, 32'(waddr2), 32'(e.a2));
    chk({tag, ".wdata2"}, wdata2,      e.d2);
    chk({tag, ".count"},  32'(count),  32'(e.cnt));
    chk({tag, ".empty"},  32'(empty),  32'(e.emp));
    chk({tag, ".ready"},  32'(in_ready), 32'(e.rdy));
    chk({tag, ".tag0"},   32'(alloc_tag0), 32'(e.tag0));
  endtask

  // One clock cycle: inputs held from just after the rising edge, outputs
  // compared on the falling edge, then advance past the next rising edge.
  task automatic cycle(input string tag, input in_t x, input exp_t e);
    drive(x);
    @(negedge clk);
    chk_out(tag, e);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[13];

  initial begin
    // Table: starts from reset, each row is one cycle.
    vecs[0]  = '{i_idle(), e_quiet(0, 1, 1, 0)};
    vecs[1]  = '{i_pair(1, 5, 32'h11, 0, 1, 6, 32'h22, 0), e_quiet(0, 1, 1, 0)};
    vecs[2]  = '{i_idle(), mk_e(1, 5, 32'h11, 1, 6, 32'h22, 2, 0, 1, 2)};
    vecs[3]  = '{i_pair(1, 8, 32'h1234, 1, 1, 9, 32'h99, 0), e_quiet(0, 1, 1, 2)};
    vecs[4]  = '{i_idle(), e_quiet(2, 0, 1, 4)};
    vecs[5]  = '{i_fill(2, 32'hDEAD), e_quiet(2, 0, 1, 4)};
    vecs[6]  = '{i_idle(), mk_e(1, 8, 32'hDEAD, 1, 9, 32'h99, 2, 0, 1, 4)};
    vecs[7]  = '{i_pair(1, 3, 32'hA, 0, 1, 3, 32'hB, 0), e_quiet(0, 1, 1, 4)};
    vecs[8]  = '{i_idle(), mk_e(1, 3, 32'hA, 1, 3, 32'hB, 2, 0, 1, 6)};
    vecs[9]  = '{i_s1(1, 12, 32'h0C), e_quiet(0, 1, 1, 6)};
    vecs[10] = '{i_idle(), mk_e(1, 12, 32'h0C, 0, 0, 0, 1, 0, 1, 7)};
    vecs[11] = '{i_pair(0, 7, 32'h55, 0, 1, 0, 32'h66, 0), e_quiet(0, 1, 1, 7)};
    vecs[12] = '{i_idle(), mk_e(0, 7, 32'h55, 1, 0, 32'h66, 2, 0, 1, 1)};

    drive(i_idle());
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_out("reset", e_quiet(0, 1, 1, 0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 13; k++)
      cycle($sformatf("vec%0d", k), vecs[k].i, vecs[k].e);

    // Fill the queue with 7 pending loads at tags 1..7 (head = tail = 1).
    cycle("full_a", i_pair(1, 17, 0, 1, 1, 18, 0, 1), e_quiet(0, 1, 1, 1));
    cycle("full_b", i_pair(1, 19, 0, 1, 1, 20, 0, 1), e_quiet(2, 0, 1, 3));
    cycle("full_c", i_pair(1, 21, 0, 1, 1, 22, 0, 1), e_quiet(4, 0, 1, 5));
    cycle("full_d", i_s0(1, 23, 0, 1),                e_quiet(6, 0, 1, 7));
    // count 7: not ready, a further pair must be refused.
    cycle("full_e", i_pair(1, 30, 32'hBAD, 0, 1, 31, 32'hBAD, 0), e_quiet(7, 0, 0, 0));
    cycle("full_f", i_idle(), e_quiet(7, 0, 0, 0));
    // Fill one tag per cycle; the entry filled last cycle drains on port 1
    // while the one being filled now is still pending and blocks port 2.
    for (int k = 1; k <= 7; k++) begin
      if (k == 1)
        cycle("fill1", i_fill(3'(k), 32'h101), e_quiet(7, 0, 0, 0));
      else
        cycle($sformatf("fill%0d", k), i_fill(3'(k), 32'h100 + 32'(k)),
              mk_e(1, 5'(16 + k - 1), 32'h100 + 32'(k - 1), 0, 0, 0,
                   4'(9 - k), 0, (9 - k) <= 6, 0));
    end
    cycle("fill_last", i_idle(), mk_e(1, 23, 32'h107, 0, 0, 0, 1, 0, 1, 0));
    cycle("wrap_enq", i_s0(1, 1, 32'h77, 0), e_quiet(0, 1, 1, 0));
    cycle("wrap_drain", i_idle(), mk_e(1, 1, 32'h77, 0, 0, 0, 1, 0, 1, 1));

    // Flush with a drainable head, same-cycle enqueue and fill.
    cycle("fl_a", i_pair(1, 24, 0, 1, 1, 25, 0, 1), e_quiet(0, 1, 1, 1));
    cycle("fl_b", i_pair(1, 26, 32'h26, 0, 1, 27, 32'h27, 0), e_quiet(2, 0, 1, 3));
    cycle("fl_c", i_fill(1, 32'hF1), e_quiet(4, 0, 1, 5));
    begin
      in_t f = i_pair(1, 28, 32'h28, 0, 1, 29, 32'h29, 0);
      f.fl = 1; f.fv = 1; f.ft = 2; f.fd = 32'hF2;
      cycle("fl_d", f, e_quiet(4, 0, 1, 5));
    end
    cycle("fl_e", i_idle(), e_quiet(0, 1, 1, 0));
    cycle("fl_f", i_idle(), e_quiet(0, 1, 1, 0));

    // Asynchronous reset in the middle of a drain.
    cycle("ar_a", i_pair(1, 10, 32'hA0, 0, 1, 11, 32'hB0, 0), e_quiet(0, 1, 1, 0));
    drive(i_idle());
    @(negedge clk);
    chk_out("ar_b", mk_e(1, 10, 32'hA0, 1, 11, 32'hB0, 2, 0, 1, 2));
    #2 rst = 1'b0;
    #1 chk_out("ar_c", e_quiet(0, 1, 1, 0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // A fill aimed at a ready entry must not change its data.
    cycle("nf_a", i_pair(1, 13, 0, 1, 1, 14, 32'h14, 0), e_quiet(0, 1, 1, 0));
    cycle("nf_b", i_fill(1, 32'hBAD), e_quiet(2, 0, 1, 2));
    cycle("nf_c", i_fill(0, 32'hC0), e_quiet(2, 0, 1, 2));
    cycle("nf_d", i_idle(), mk_e(1, 13, 32'hC0, 1, 14, 32'h14, 2, 0, 1, 2));
    cycle("nf_e", i_idle(), e_quiet(0, 1, 1, 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
